alu_operand_stage: RTL and testbench
====================================

// Module: alu_operand_stage
// PURPOSE
//  Decode/operand/writeback stage wrapped around the combinational 16-bit ALU.
//  - Accepts 16-bit instructions on a valid/ready handshake.
//  - Holds the 16x16 register file and the 5-bit PSR (C,L,F,Z,N).
//  - Drives ALU operands A/B and opcode/opext; captures ALU S and CLFZN.
//  - Writes S back to the register file and CLFZN into the PSR.
// PARAMETERS
//  NREGS     16  number of GPRs; sets the register index width (log2 NREGS = 4)
//  IMM_W     8   immediate field width, inst[7:0]
// PORTS
//  clk        in   1   rising-edge clock; all state changes on this edge
//  reset_n    in   1   synchronous, active-low reset
//  in_valid   in   1   instruction offered
//  in_ready   out  1   stage can accept (= ~stall)
//  in_inst    in   16  [15:12] opcode, [11:8] Rdest, [7:4] opext, [3:0] Rsrc; imm = [7:0]
//  stall      in   1   hold: no accept, no writeback while high
//  alu_a      out  16  ALU operand A
//  alu_b      out  16  ALU operand B
//  alu_op     out  4   ALU opcode
//  alu_ext    out  4   ALU opext
//  alu_s      in   16  ALU result (combinational from alu_a/alu_b/alu_op/alu_ext)
//  alu_flags  in   5   ALU CLFZN
//  psr        out  5   architectural flags {C,L,F,Z,N}
//  wb_valid   out  1   1-cycle pulse: instruction retired this edge
//  dbg_addr   in   4   debug read address
//  dbg_data   out  16  R[dbg_addr], combinational, reflects writes after the edge
// BEHAVIOUR
//  Reset (reset_n=0 at edge):
//   - all GPRs = 0, psr = 0, ex_valid = 0, wb_valid = 0.
//   - Outputs alu_op/alu_ext/alu_a/alu_b = 0 (NOP) whenever ex_valid = 0.
//  Reset wins over every other event; an instruction held mid-execution is discarded.
//  Handshake:
//   - Accept when in_valid & in_ready at edge; inst latched into EX register, ex_valid = 1.
//   - in_valid with no accept: no state change. in_ready is combinational ~stall.
//  EX cycle (ex_valid=1, stall=0), states IDLE(ex_valid=0)/EX(ex_valid=1):
//   - Operands read combinationally from the regfile.
//   - At the next edge: R[Rdest] <= alu_s (if write enabled); psr <= alu_flags; wb_valid = 1.
//   - EX->EX when a new inst is accepted the same edge; otherwise EX->IDLE.
//   - Throughput 1 inst/cycle. No hazards: the regfile is written at the same edge the
//     next inst enters EX.
//  stall=1 while in EX: EX register, regfile and psr frozen; wb_valid = 0; ALU outputs held.
//  Operand select:
//   - Register form (op 0000 or 1010): A = R[Rdest], B = R[Rsrc].
//     Exception MOV (0000_1101): A = R[Rsrc].
//   - Immediate forms:
//     - A = R[Rdest], B = imm.
//     - imm sign-extended for 0101 ADDI, 0111 ADDCI, 1001 SUBI, 1011 CMPI.
//     - imm zero-extended for 0110 ADDUI.
//     - MOVI (1101): A = zero-extended imm, B = 0.
//     - LSHI (1000) / RSHI (1110): A = R[Rdest], B = 0.
//  Write enable = 0 for CMP 0000_1011, CMPI 1011_xxxx, CMPU 1010_0010, NOP 0000_0000.
//  psr is updated for every retired inst except NOP.
//  Rdest == Rsrc is legal; the read returns the pre-write value.
//  16-bit writeback, no truncation logic; 8-bit to 16-bit extension only at the B/A mux.
//  The EX register holds Rdest, so writeback lands on the correct register even if
//  in_inst changes during a stall.
// TESTING
//  1 Reset: reset_n=0 one edge after random traffic -> all dbg reads 0, psr=0, wb_valid=0.
//  2 MOVI R1,0x7F; MOVI R2,0x01; ADD R1,R2 back-to-back, no stall
//     -> R1=0x0080, psr.F=1, one wb_valid pulse per inst.
//  3 Sign extension: ADDI R3,0xFF with R3=0x0005 -> R3=0x0004.
//    ADDUI R4,0xFF with R4=0 -> R4=0x00FF.
//  4 CMP R5,R6 with R5=3, R6=3 -> R5/R6 unchanged, psr=5'b00010.
//    CMPI R5,0x02 -> psr.L=1, psr.N=1, regfile unchanged.
//  5 stall=1 for 3 cycles with SUB R7,R8 in EX -> no write and no wb_valid during stall;
//    R7=R7-R8 exactly one edge after stall falls.
//  6 reset_n=0 on the edge an ADD would retire -> destination stays 0, psr=0.

Source files
------------

// File: rtl/alu_operand_stage.sv
// Decode/operand/writeback stage around an external combinational ALU; one EX register, 1 inst/cycle.
// Result retires one edge after acceptance; i_stall freezes EX/regfile/psr and deasserts o_in_ready.
module alu_operand_stage #(
  parameter int NREGS = 16,
  parameter int IMM_W = 8
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic [15:0]              i_in_inst,
  input  logic                     i_stall,
  output logic [15:0]              o_alu_a,
  output logic [15:0]              o_alu_b,
  output logic [3:0]               o_alu_op,
  output logic [3:0]               o_alu_ext,
  input  logic [15:0]              i_alu_s,
  input  logic [4:0]               i_alu_flags,
  output logic [4:0]               o_psr,
  output logic                     o_wb_valid,
  input  logic [$clog2(NREGS)-1:0] i_dbg_addr,
  output logic [15:0]              o_dbg_data
);

  localparam int RIDX_W = $clog2(NREGS);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EX   = 1'b1;

  localparam logic [3:0] OP_REG   = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h5;
  localparam logic [3:0] OP_ADDUI = 4'h6;
  localparam logic [3:0] OP_ADDCI = 4'h7;
  localparam logic [3:0] OP_LSHI  = 4'h8;
  localparam logic [3:0] OP_SUBI  = 4'h9;
  localparam logic [3:0] OP_REG2  = 4'hA;
  localparam logic [3:0] OP_CMPI  = 4'hB;
  localparam logic [3:0] OP_MOVI  = 4'hD;
  localparam logic [3:0] OP_RSHI  = 4'hE;

  localparam logic [3:0] EXT_NOP  = 4'h0;
  localparam logic [3:0] EXT_CMPU = 4'h2;
  localparam logic [3:0] EXT_CMP  = 4'hB;
  localparam logic [3:0] EXT_MOV  = 4'hD;

  logic [0:0]        r_state;
  logic [15:0]       r_ex_inst;
  logic [15:0]       r_regs [NREGS];
  logic [4:0]        r_psr;
  logic              r_wb_valid;

  logic              w_ex_valid;
  logic [3:0]        w_op;
  logic [3:0]        w_ext;
  logic [RIDX_W-1:0] w_rd;
  logic [RIDX_W-1:0] w_rs;
  logic [IMM_W-1:0]  w_imm;
  logic [15:0]       w_imm_sext;
  logic [15:0]       w_imm_zext;
  logic [15:0]       w_rd_val;
  logic [15:0]       w_rs_val;
  logic              w_reg_form;
  logic              w_nop;
  logic              w_we;

  assign w_ex_valid = (r_state == S_EX);
  assign w_op       = r_ex_inst[15:12];
  assign w_ext      = r_ex_inst[7:4];
  assign w_rd       = r_ex_inst[8 +: RIDX_W];
  assign w_rs       = r_ex_inst[0 +: RIDX_W];
  assign w_imm      = r_ex_inst[IMM_W-1:0];
  assign w_imm_sext = {{(16-IMM_W){w_imm[IMM_W-1]}}, w_imm};
  assign w_imm_zext = {{(16-IMM_W){1'b0}}, w_imm};
  assign w_rd_val   = r_regs[w_rd];
  assign w_rs_val   = r_regs[w_rs];
  assign w_reg_form = (w_op == OP_REG) || (w_op == OP_REG2);

  assign w_nop = (w_op == OP_REG) && (w_ext == EXT_NOP);
  assign w_we  = !(w_nop
                   || ((w_op == OP_REG)  && (w_ext == EXT_CMP))
                   || (w_op == OP_CMPI)
                   || ((w_op == OP_REG2) && (w_ext == EXT_CMPU)));

  // Operands come straight from the regfile; an idle stage presents a NOP.
  always_comb begin
    o_alu_a   = '0;
    o_alu_b   = '0;
    o_alu_op  = '0;
    o_alu_ext = '0;
    if (w_ex_valid) begin
      o_alu_op  = w_op;
      o_alu_ext = w_ext;
      if (w_reg_form) begin
        o_alu_a = ((w_op == OP_REG) && (w_ext == EXT_MOV)) ? w_rs_val : w_rd_val;
        o_alu_b = w_rs_val;
      end else begin
        case (w_op)
          OP_MOVI: begin
            o_alu_a = w_imm_zext;
            o_alu_b = '0;
          end
          OP_LSHI, OP_RSHI: begin
            o_alu_a = w_rd_val;
            o_alu_b = '0;
          end
          OP_ADDI, OP_ADDCI, OP_SUBI, OP_CMPI: begin
            o_alu_a = w_rd_val;
            o_alu_b = w_imm_sext;
          end
          default: begin
            o_alu_a = w_rd_val;
            o_alu_b = w_imm_zext;
          end
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state    <= S_IDLE;
      r_ex_inst  <= '0;
      r_psr      <= '0;
      r_wb_valid <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_wb_valid <= 1'b0;
      if (!i_stall) begin
        // Retire the EX instruction while the next one (if any) takes its place.
        if (w_ex_valid) begin
          if (w_we) begin
            r_regs[w_rd] <= i_alu_s;
          end
          if (!w_nop) begin
            r_psr <= i_alu_flags;
          end
          r_wb_valid <= 1'b1;
        end
        r_state <= i_in_valid ? S_EX : S_IDLE;
        if (i_in_valid) begin
          r_ex_inst <= i_in_inst;
        end
      end
    end
  end

  assign o_in_ready = ~i_stall;
  assign o_psr      = r_psr;
  assign o_wb_valid = r_wb_valid;
  assign o_dbg_data = r_regs[i_dbg_addr];

endmodule

// File: tb/tb_alu_operand_stage.sv
`timescale 1ns/10ps
// Random + directed bench: reference model predicts each retirement, monitor checks on wb_valid.
module tb_alu_operand_stage;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_inst;
  logic        stall;
  logic [15:0] alu_a, alu_b, alu_s;
  logic [3:0]  alu_op, alu_ext;
  logic [4:0]  alu_flags;
  logic [4:0]  psr;
  logic        wb_valid;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;

  logic        sweep_en;
  logic [3:0]  sweep_addr;
  logic [3:0]  mon_addr;

  int checks = 0;
  int errors = 0;
  int wb_count = 0;

  typedef struct packed {
    logic [3:0]  rd;
    logic [15:0] val;
    logic [4:0]  psr;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] m_regs [16];
  logic [4:0]  m_psr;
  logic        m_ex;
  logic        exp_wb;

  alu_operand_stage dut (
    .i_clk       (clk),
    .i_reset_n   (reset_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_inst   (in_inst),
    .i_stall     (stall),
    .o_alu_a     (alu_a),
    .o_alu_b     (alu_b),
    .o_alu_op    (alu_op),
    .o_alu_ext   (alu_ext),
    .i_alu_s     (alu_s),
    .i_alu_flags (alu_flags),
    .o_psr       (psr),
    .o_wb_valid  (wb_valid),
    .i_dbg_addr  (dbg_addr),
    .o_dbg_data  (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dbg_addr = sweep_en ? sweep_addr : mon_addr;

  // Environment ALU: returns {C,L,F,Z,N,S}; F is the signed byte overflow of adds.
  function automatic logic [20:0] alu_fn(input logic [3:0] op, input logic [3:0] ext,
                                         input logic [15:0] a, input logic [15:0] b);
    logic [16:0] t;
    logic [15:0] s;
    logic c, l, f, z, n;
    s = a ^ b; c = 0; l = 0; f = 0;
    if ((op == 4'h0 && ext inside {4'h5, 4'h6, 4'h7}) || op inside {4'h5, 4'h6, 4'h7}) begin
      t = {1'b0, a} + {1'b0, b};
      s = t[15:0]; c = t[16];
      f = (a[7] == b[7]) && (s[7] != a[7]);
    end else if ((op == 4'h0 && ext == 4'h9) || op == 4'h9) begin
      t = {1'b0, a} - {1'b0, b};
      s = t[15:0]; c = t[16];
      f = (a[15] != b[15]) && (s[15] != a[15]);
    end else if (op == 4'hD || (op == 4'h0 && ext == 4'hD)) begin
      s = a;
    end else if (op == 4'h8) begin
      s = a << ext;
    end else if (op == 4'hE) begin
      s = a >> ext;
    end
    z = (s == 16'h0);
    n = s[15];
    if ((op == 4'h0 && ext == 4'hB) || op == 4'hB || (op == 4'hA && ext == 4'h2)) begin
      z = (a == b);
      l = (a > b);
      n = ($signed(a) > $signed(b));
      c = 0; f = 0;
    end
    return {c, l, f, z, n, s};
  endfunction

  assign {alu_flags, alu_s} = alu_fn(alu_op, alu_ext, alu_a, alu_b);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Architectural effect of one instruction, applied in program order.
  task automatic model_apply(input logic [15:0] inst);
    logic [3:0]  op, rd, ext, rs;
    logic [7:0]  imm;
    logic [15:0] a, b;
    logic [20:0] r;
    logic        nop, we;
    exp_t        e;
    op = inst[15:12]; rd = inst[11:8]; ext = inst[7:4]; rs = inst[3:0]; imm = inst[7:0];
    if (op == 4'h0 || op == 4'hA) begin
      a = (op == 4'h0 && ext == 4'hD) ? m_regs[rs] : m_regs[rd];
      b = m_regs[rs];
    end else if (op == 4'hD) begin
      a = {8'h00, imm}; b = 16'h0;
    end else if (op == 4'h8 || op == 4'hE) begin
      a = m_regs[rd]; b = 16'h0;
    end else begin
      a = m_regs[rd];
      b = (op inside {4'h5, 4'h7, 4'h9, 4'hB}) ? {{8{imm[7]}}, imm} : {8'h00, imm};
    end
    r   = alu_fn(op, ext, a, b);
    nop = (op == 4'h0) && (ext == 4'h0);
    we  = !(nop || (op == 4'h0 && ext == 4'hB) || op == 4'hB || (op == 4'hA && ext == 4'h2));
    if (we)   m_regs[rd] = r[15:0];
    if (!nop) m_psr = r[20:16];
    e.rd = rd; e.val = m_regs[rd]; e.psr = m_psr;
    exp_q.push_back(e);
  endtask

  initial begin
    m_ex = 0; exp_wb = 0; m_psr = 0;
    for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
        m_psr = 0; m_ex = 0; exp_wb = 0;
        exp_q.delete();
      end else begin
        exp_wb = !stall && m_ex;
        if (!stall) begin
          if (in_valid) model_apply(in_inst);
          m_ex = in_valid;
        end
      end
    end
  end

  initial begin
    exp_t e;
    mon_addr = 4'h0;
    forever begin
      @(negedge clk);
      check("wb_valid_timing", wb_valid, exp_wb);
      if (!m_ex) check("idle_nop_outputs", {alu_op, alu_ext, alu_a, alu_b}, 32'h0);
      if (wb_valid) begin
        wb_count++;
        if (exp_q.size() == 0) begin
          check("wb_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          mon_addr = e.rd;
          #1;
          check("wb_reg", dbg_data, e.val);
          check("wb_psr", psr, e.psr);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [15:0] inst);
    in_valid = 1'b1;
    in_inst  = inst;
    step();
    in_valid = 1'b0;
  endtask

  task automatic chk_reg(input string name, input logic [3:0] addr, input logic [15:0] exp);
    sweep_en = 1'b1;
    sweep_addr = addr;
    #0.1;
    check(name, dbg_data, exp);
    sweep_en = 1'b0;
  endtask

  task automatic reset_sweep(input string name);
    sweep_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      sweep_addr = i[3:0];
      #0.1;
      check({name, "_reg"}, dbg_data, 16'h0);
    end
    sweep_en = 1'b0;
    check({name, "_psr"}, psr, 5'b0);
    check({name, "_wb"}, wb_valid, 1'b0);
  endtask

  initial begin
    int w0;
    reset_n = 1'b0; in_valid = 1'b0; in_inst = 16'h0; stall = 1'b0;
    sweep_en = 1'b0; sweep_addr = 4'h0;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    reset_sweep("rst_init");

    // MOVI R1,7F; MOVI R2,01; ADD R1,R2
    w0 = wb_count;
    issue(16'hD17F); issue(16'hD201); issue(16'h0152);
    repeat (3) step();
    chk_reg("t2_r1", 4'd1, 16'h0080);
    check("t2_psr_f", psr[2], 1'b1);
    check("t2_wb_pulses", wb_count - w0, 3);

    // ADDI sign-extends, ADDUI zero-extends
    issue(16'hD305); issue(16'h53FF); issue(16'hD400); issue(16'h64FF);
    repeat (3) step();
    chk_reg("t3_addi", 4'd3, 16'h0004);
    chk_reg("t3_addui", 4'd4, 16'h00FF);

    // CMP equal, then CMPI against smaller immediate
    issue(16'hD503); issue(16'hD603); issue(16'h05B6);
    repeat (3) step();
    chk_reg("t4_cmp_r5", 4'd5, 16'h0003);
    chk_reg("t4_cmp_r6", 4'd6, 16'h0003);
    check("t4_cmp_psr", psr, 5'b00010);
    issue(16'hB502);
    repeat (3) step();
    check("t4_cmpi_psr", psr, 5'b01001);
    chk_reg("t4_cmpi_r5", 4'd5, 16'h0003);

    // SUB R7,R8 held in EX by a 3-cycle stall while in_inst wiggles
    issue(16'hD750); issue(16'hD810); issue(16'h0798);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_inst  = 16'($urandom);
      #0.1;
      check("t5_ready_low", in_ready, 1'b0);
      step();
      chk_reg("t5_r7_frozen", 4'd7, 16'h0050);
    end
    stall = 1'b0; in_valid = 1'b0;
    #0.1;
    check("t5_ready_high", in_ready, 1'b1);
    step();
    chk_reg("t5_r7_sub", 4'd7, 16'h0040);

    // Random traffic with a reset dropped into the middle
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        reset_n  = 1'b0;
        stall    = 1'b0;
        in_valid = 1'($urandom);
        in_inst  = 16'($urandom);
        step();
        reset_n  = 1'b1;
        in_valid = 1'b0;
        reset_sweep("rst_traffic");
      end else begin
        stall    = ($urandom_range(0, 4) == 0);
        in_valid = ($urandom_range(0, 9) < 7);
        in_inst  = 16'($urandom);
        step();
      end
    end
    stall = 1'b0; in_valid = 1'b0;
    repeat (3) step();
    check("traffic_drained", exp_q.size(), 0);

    // Reset lands on the edge an ADD would retire
    issue(16'hD905);
    issue(16'h0959);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    reset_sweep("rst_retire");
    repeat (2) step();
    check("final_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
